operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Feeds the combinational ALU in the multi-cycle TSC datapath.
- Holds the 4 x 16-bit register file and produces the latched A/B operands and the 4-bit ALU OP.
- Selects and extends the immediate, and stalls on register hazards using a pending-write scoreboard.
- Accepts instructions from control via a valid/ready handshake and presents them to the ALU through a one-entry output register.

Parameters:
- WORD_SIZE, 16, datapath width.
- NUM_REGS, 4, architectural registers.
- REG_ADDR_W, 2, register index width (log2 NUM_REGS).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  control presents an instruction.
- in_ready  output  1  stage accepts an instruction this cycle.
- rs  input  REG_ADDR_W  source for A.
- rt  input  REG_ADDR_W  source for B when b_sel=00.
- rd  input  REG_ADDR_W  destination of the issuing instruction.
- rd_writes  input  1  the issuing instruction will write rd.
- imm  input  8  instruction immediate.
- b_sel  input  2  B source: 00 reg[rt], 01 sign-extended imm, 10 zero-extended imm, 11 zero.
- op_in  input  4  ALU OP code from the shared opcode constants.
- out_valid  output  1  A_out/B_out/op_out valid for the ALU.
- out_ready  input  1  ALU side consumes this cycle.
- A_out  output  WORD_SIZE  operand A.
- B_out  output  WORD_SIZE  operand B.
- op_out  output  4  latched ALU OP.
- wr_en  input  1  writeback strobe.
- wr_addr  input  REG_ADDR_W  writeback register.
- wr_data  input  WORD_SIZE  writeback value.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - all registers, A_out, B_out and op_out go to 0; out_valid=0; all pending bits=0.
  - An in-flight output entry is discarded, not delivered.
  - in_ready is 0 while reset_n=0.
- Register file:
  - Write on a clk edge when wr_en=1.
  - The same edge clears pending[wr_addr].
- Hazard check (combinational): hazard = (pending[rs] & ~clr_rs) | (b_sel==00 & pending[rt] & ~clr_rt) | (rd_writes & pending[rd] & ~clr_rd).
  - clr_x = wr_en & wr_addr==x.
  - This covers RAW on both sources and WAW on the destination, so at most one write is outstanding per register.
- Ready: in_ready = reset_n & ~hazard & (~out_valid | out_ready).
- Accept (in_valid & in_ready):
  - Latch A_out, B_out and op_out; set out_valid=1.
  - If rd_writes, set pending[rd]; set wins over a same-cycle clear of the same register.
- Bypass: when a read address equals wr_addr and wr_en=1 in the accept cycle, the operand takes wr_data, not the stale array value.
- Immediate extension:
  - sign-extend: {{8{imm[7]}}, imm}.
  - zero-extend: {8'h00, imm}.
- Output register behaviour:
  - out_ready=1 with no accept: out_valid drops to 0.
  - out_ready=1 with a simultaneous accept: the entry is replaced; this is full throughput, one per cycle.
  - out_valid=1 and out_ready=0: outputs hold and in_ready=0.
- Latency: 1 cycle from accept to out_valid.
- Only clr_x terms cover writes that land in the accept cycle; no other forwarding path exists.
- Writes to any register, r0 included, are architectural (no hardwired zero).
- Illegal b_sel does not exist, since all 4 codes are defined.

Decomposition:
- WORD_SIZE, NUM_REGS, the b_sel encodings (BSEL_REG, BSEL_SEXT, BSEL_ZEXT, BSEL_ZERO) and the ALU OP codes belong in the shared constants/opcodes includes.
- One natural sub-module: reg_file_2r1w, holding the 4 x 16 array with two async read ports and one sync write port; bypass and scoreboard stay in the parent.

Test Plan:
- Reset, then write r1=16'h1234, r2=16'h0F0F; issue rs=1, rt=2, b_sel=00, op=ADD, out_ready=1 -> next cycle out_valid=1, A_out=16'h1234, B_out=16'h0F0F, op_out=ADD.
- Issue b_sel=01 with imm=8'hF0 -> B_out=16'hFFF0; b_sel=10 with imm=8'hF0 -> B_out=16'h00F0.
- Issue rd=3, rd_writes=1, then a next instruction with rs=3 -> in_ready=0 until the cycle with wr_en=1, wr_addr=3, wr_data=16'hBEEF; in that cycle the instruction is accepted and A_out=16'hBEEF (bypass).
- Hold out_ready=0 for 3 cycles with in_valid=1 -> outputs stable and in_ready=0; then out_ready=1 for back-to-back issues -> one accept per cycle.
- Same-cycle wr_en to r2 and issue with rd=2, rd_writes=1 -> pending[2]=1 afterwards; a following read of r2 stalls.
- Assert reset_n=0 while out_valid=1 and pending[1]=1 -> next cycle out_valid=0, pending cleared, A_out=B_out=0, all registers read 0.

Source files
------------

// File: rtl/operand_fetch_stage_pkg.sv
// Shared constants for the operand fetch stage: datapath sizes, B-source
// encodings and ALU opcodes, plus the B-operand selection helper.
package operand_fetch_stage_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int NUM_REGS   = 4;
    localparam int REG_ADDR_W = 2;
    localparam int IMM_W      = 8;
    localparam int OP_W       = 4;

    typedef enum logic [1:0] {
        BSEL_REG  = 2'b00,
        BSEL_SEXT = 2'b01,
        BSEL_ZEXT = 2'b10,
        BSEL_ZERO = 2'b11
    } bsel_e;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_NOT   = 4'h5,
        OP_SHL   = 4'h6,
        OP_SHR   = 4'h7,
        OP_PASSA = 4'h8,
        OP_PASSB = 4'h9
    } alu_op_e;

    // B operand: register value, sign/zero-extended immediate, or zero.
    function automatic logic [WORD_SIZE-1:0] select_b(
        input bsel_e                 sel,
        input logic [WORD_SIZE-1:0]  reg_val,
        input logic [IMM_W-1:0]      imm
    );
        logic [WORD_SIZE-1:0] result;
        case (sel)
            BSEL_REG:  result = reg_val;
            BSEL_SEXT: result = {{(WORD_SIZE-IMM_W){imm[IMM_W-1]}}, imm};
            BSEL_ZEXT: result = {{(WORD_SIZE-IMM_W){1'b0}}, imm};
            default:   result = '0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/operand_fetch_stage_reg_file.sv
// 4 x 16 architectural register file: two asynchronous read ports and one
// synchronous write port. Registers clear on reset, so this maps to flops.
module reg_file_2r1w
    import operand_fetch_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [WORD_SIZE-1:0]  wr_data,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [WORD_SIZE-1:0]  rd_data_a,
    output logic [WORD_SIZE-1:0]  rd_data_b
);

    logic [WORD_SIZE-1:0] r_regs [NUM_REGS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            // Each register clears on reset and loads on a matching write.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_regs[gi] <= '0;
                end else if (wr_en && (wr_addr == REG_ADDR_W'(gi))) begin
                    r_regs[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign rd_data_a = r_regs[rd_addr_a];
    assign rd_data_b = r_regs[rd_addr_b];

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: reads A/B from the register file (with writeback
// bypass), extends the immediate, stalls on pending writes and hands the
// operands to the ALU through a one-entry valid/ready output register.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  rd_writes,
    input  logic [IMM_W-1:0]      imm,
    input  logic [1:0]            b_sel,
    input  logic [OP_W-1:0]       op_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_SIZE-1:0]  A_out,
    output logic [WORD_SIZE-1:0]  B_out,
    output logic [OP_W-1:0]       op_out,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [WORD_SIZE-1:0]  wr_data
);

    logic                 r_out_valid;
    logic [WORD_SIZE-1:0] r_a;
    logic [WORD_SIZE-1:0] r_b;
    logic [OP_W-1:0]      r_op;
    logic [NUM_REGS-1:0]  r_pending;

    logic [WORD_SIZE-1:0] w_rf_a;
    logic [WORD_SIZE-1:0] w_rf_b;
    logic [WORD_SIZE-1:0] w_a;
    logic [WORD_SIZE-1:0] w_rt_val;
    logic [WORD_SIZE-1:0] w_b;
    logic [NUM_REGS-1:0]  w_clr;
    logic [NUM_REGS-1:0]  w_set;
    logic                 w_hazard;
    logic                 w_accept;

    reg_file_2r1w u_reg_file (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rs),
        .rd_addr_b (rt),
        .rd_data_a (w_rf_a),
        .rd_data_b (w_rf_b)
    );

    // A writeback landing this edge retires the pending bit of its register.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_clr
            assign w_clr[gi] = wr_en && (wr_addr == REG_ADDR_W'(gi));
        end
    endgenerate

    // RAW on rs/rt (rt only when B reads the register) and WAW on rd;
    // a write landing this cycle lifts the stall for its register.
    assign w_hazard = (r_pending[rs] & ~w_clr[rs])
                    | ((b_sel == BSEL_REG) & r_pending[rt] & ~w_clr[rt])
                    | (rd_writes & r_pending[rd] & ~w_clr[rd]);

    assign in_ready = reset_n & ~w_hazard & (~r_out_valid | out_ready);
    assign w_accept = in_valid & in_ready;

    // Same-cycle writeback is forwarded so the operand never sees a stale value.
    assign w_a      = (wr_en && (wr_addr == rs)) ? wr_data : w_rf_a;
    assign w_rt_val = (wr_en && (wr_addr == rt)) ? wr_data : w_rf_b;
    assign w_b      = select_b(bsel_e'(b_sel), w_rt_val, imm);

    assign w_set = (w_accept && rd_writes) ? (NUM_REGS'(1) << rd) : '0;

    // Output register and scoreboard; a new pending set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_pending   <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_a         <= w_a;
                r_b         <= w_b;
                r_op        <= op_in;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    assign out_valid = r_out_valid;
    assign A_out     = r_a;
    assign B_out     = r_b;
    assign op_out    = r_op;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: a register-file model feeds a
// scoreboard queue on every accept; each delivered output is popped and compared.
module tb_operand_fetch_stage;
    import operand_fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  rs, rt, rd;
    logic        rd_writes;
    logic [7:0]  imm;
    logic [1:0]  b_sel;
    logic [3:0]  op_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] A_out, B_out;
    logic [3:0]  op_out;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] m_regs [4];
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_delivered = 0;

    always #5 clk = ~clk;

    operand_fetch_stage dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .rd_writes (rd_writes),
        .imm       (imm),
        .b_sel     (b_sel),
        .op_in     (op_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A_out     (A_out),
        .B_out     (B_out),
        .op_out    (op_out),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural register model.
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) m_regs[i] <= '0;
        end else if (wr_en) begin
            m_regs[wr_addr] <= wr_data;
        end
    end

    // Scoreboard: pop/compare delivered outputs, push expected on accept.
    always @(negedge clk) begin
        exp_t e;
        logic [15:0] ea, eb, rtv;
        if (!reset_n) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_delivered++;
                $display("[TB] out A=%h B=%h op=%h", A_out, B_out, op_out);
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("sb_A", {16'h0, A_out}, {16'h0, e.a});
                    check_eq("sb_B", {16'h0, B_out}, {16'h0, e.b});
                    check_eq("sb_op", {28'h0, op_out}, {28'h0, e.op});
                end
            end
            if (in_valid && in_ready) begin
                ea  = (wr_en && wr_addr == rs) ? wr_data : m_regs[rs];
                rtv = (wr_en && wr_addr == rt) ? wr_data : m_regs[rt];
                case (b_sel)
                    2'b00:   eb = rtv;
                    2'b01:   eb = {{8{imm[7]}}, imm};
                    2'b10:   eb = {8'h00, imm};
                    default: eb = 16'h0000;
                endcase
                sb_q.push_back('{a: ea, b: eb, op: op_in});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction at P+1, require it to be accepted this cycle.
    task automatic issue(input logic [1:0] t_rs, input logic [1:0] t_rt, input logic [1:0] t_rd,
                         input logic t_rdw, input logic [7:0] t_imm, input logic [1:0] t_bsel,
                         input logic [3:0] t_op, input string tag);
        rs = t_rs; rt = t_rt; rd = t_rd; rd_writes = t_rdw;
        imm = t_imm; b_sel = t_bsel; op_in = t_op; in_valid = 1'b1;
        @(negedge clk);
        check_eq(tag, {31'h0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        rd_writes = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; rs = '0; rt = '0; rd = '0; rd_writes = 1'b0;
        imm = '0; b_sel = '0; op_in = '0; out_ready = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_in_ready", {31'h0, in_ready}, 32'd0);
        check_eq("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check_eq("rst_A", {16'h0, A_out}, 32'h0);
        check_eq("rst_B", {16'h0, B_out}, 32'h0);
        check_eq("rst_op", {28'h0, op_out}, 32'h0);
        tick();
        reset_n = 1'b1;

        // Load r1, r2 then an ADD of them.
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'h1234;
        tick();
        wr_addr = 2'd2; wr_data = 16'h0F0F;
        tick();
        wr_en = 1'b0;
        out_ready = 1'b1;
        issue(2'd1, 2'd2, 2'd0, 1'b0, 8'h00, BSEL_REG, OP_ADD, "acc_add");
        @(negedge clk);
        check_eq("add_valid", {31'h0, out_valid}, 32'd1);
        check_eq("add_A", {16'h0, A_out}, 32'h1234);
        check_eq("add_B", {16'h0, B_out}, 32'h0F0F);
        check_eq("add_op", {28'h0, op_out}, {28'h0, OP_ADD});
        tick();
        @(negedge clk);
        check_eq("drain_valid", {31'h0, out_valid}, 32'd0);
        tick();

        // Immediate extensions and zero source.
        issue(2'd0, 2'd0, 2'd0, 1'b0, 8'hF0, BSEL_SEXT, OP_PASSB, "acc_sext");
        @(negedge clk);
        check_eq("sext_B", {16'h0, B_out}, 32'hFFF0);
        tick();
        issue(2'd0, 2'd0, 2'd0, 1'b0, 8'hF0, BSEL_ZEXT, OP_PASSB, "acc_zext");
        @(negedge clk);
        check_eq("zext_B", {16'h0, B_out}, 32'h00F0);
        tick();
        issue(2'd2, 2'd1, 2'd0, 1'b0, 8'hF0, BSEL_ZERO, OP_PASSA, "acc_zero");
        @(negedge clk);
        check_eq("zero_B", {16'h0, B_out}, 32'h0000);
        check_eq("zero_A", {16'h0, A_out}, 32'h0F0F);
        tick();

        // RAW stall on r3 released by a same-cycle writeback with bypass.
        issue(2'd0, 2'd0, 2'd3, 1'b1, 8'h00, BSEL_ZERO, OP_ADD, "acc_wr3");
        rs = 2'd3; rt = 2'd0; rd = 2'd0; rd_writes = 1'b0; b_sel = BSEL_ZERO; op_in = OP_PASSA;
        in_valid = 1'b1;
        @(negedge clk);
        check_eq("raw_stall0", {31'h0, in_ready}, 32'd0);
        tick();
        @(negedge clk);
        check_eq("raw_stall1", {31'h0, in_ready}, 32'd0);
        tick();
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 16'hBEEF;
        @(negedge clk);
        check_eq("raw_release", {31'h0, in_ready}, 32'd1);
        tick();
        wr_en = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_eq("bypass_valid", {31'h0, out_valid}, 32'd1);
        check_eq("bypass_A", {16'h0, A_out}, 32'hBEEF);
        tick();

        // Backpressure: entry holds for 3 cycles, then back-to-back issues.
        out_ready = 1'b0;
        issue(2'd1, 2'd2, 2'd0, 1'b0, 8'h00, BSEL_REG, OP_SUB, "acc_bp");
        rs = 2'd2; rt = 2'd1; b_sel = BSEL_REG; op_in = OP_AND; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_in_ready", {31'h0, in_ready}, 32'd0);
            check_eq("bp_valid", {31'h0, out_valid}, 32'd1);
            check_eq("bp_A", {16'h0, A_out}, 32'h1234);
            check_eq("bp_B", {16'h0, B_out}, 32'h0F0F);
            check_eq("bp_op", {28'h0, op_out}, {28'h0, OP_SUB});
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rs = 2'(i); rt = 2'(3 - i); b_sel = BSEL_REG; op_in = OP_OR; in_valid = 1'b1;
            @(negedge clk);
            check_eq("b2b_in_ready", {31'h0, in_ready}, 32'd1);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("b2b_last_valid", {31'h0, out_valid}, 32'd1);
        tick();
        @(negedge clk);
        check_eq("b2b_drain", {31'h0, out_valid}, 32'd0);
        tick();

        // Pending set on r2 wins over a same-cycle write to r2.
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'h5555;
        issue(2'd0, 2'd0, 2'd2, 1'b1, 8'h00, BSEL_ZERO, OP_ADD, "acc_setclr");
        wr_en = 1'b0;
        rs = 2'd2; rt = 2'd0; b_sel = BSEL_ZERO; op_in = OP_PASSA; in_valid = 1'b1;
        @(negedge clk);
        check_eq("setwin_stall0", {31'h0, in_ready}, 32'd0);
        tick();
        @(negedge clk);
        check_eq("setwin_stall1", {31'h0, in_ready}, 32'd0);
        tick();
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'h7777;
        @(negedge clk);
        check_eq("setwin_release", {31'h0, in_ready}, 32'd1);
        tick();
        wr_en = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_eq("setwin_A", {16'h0, A_out}, 32'h7777);
        tick();

        // Reset with an entry in flight and r1 pending.
        out_ready = 1'b0;
        issue(2'd1, 2'd1, 2'd1, 1'b1, 8'h00, BSEL_REG, OP_ADD, "acc_pre_rst");
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("rst2_in_ready", {31'h0, in_ready}, 32'd0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst2_valid", {31'h0, out_valid}, 32'd0);
        check_eq("rst2_A", {16'h0, A_out}, 32'h0);
        check_eq("rst2_B", {16'h0, B_out}, 32'h0);
        tick();
        out_ready = 1'b1;
        issue(2'd1, 2'd2, 2'd1, 1'b1, 8'h00, BSEL_REG, OP_ADD, "post_rst_acc1");
        @(negedge clk);
        check_eq("post_rst_A1", {16'h0, A_out}, 32'h0);
        check_eq("post_rst_B1", {16'h0, B_out}, 32'h0);
        tick();
        issue(2'd3, 2'd0, 2'd0, 1'b0, 8'h00, BSEL_REG, OP_ADD, "post_rst_acc2");
        @(negedge clk);
        check_eq("post_rst_A2", {16'h0, A_out}, 32'h0);
        check_eq("post_rst_B2", {16'h0, B_out}, 32'h0);
        repeat (3) tick();

        @(negedge clk);
        check_eq("sb_drained", sb_q.size(), 32'd0);
        check_eq("delivered", n_delivered, 32'd15);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
